// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
//
// Sequential shift-add multiply-accumulate with a fixed latency:
//   product = quotientin * divisorin + remainderin
//
// Ports
//   clk          in   1   rising-edge clock for all state
//   reset        in   1   asynchronous, active-low reset
//   start        in   1   request pulse; operands follow on the next cycle
//   quotientin   in   8   unsigned multiplicand
//   divisorin    in   7   unsigned multiplier (0 is legal)
//   remainderin  in   7   unsigned addend (may exceed divisorin)
//   product      out  15  registered result
//   valid        out  1   product holds the most recent completed request
//   state_dbg    out  3   current FSM state, for observation only
//
// Request protocol: start is sampled at a rising edge (call it E0). The
// operands are sampled at the following edge E1 and nowhere else. The result
// is written to product, and valid rises, at edge E17 exactly; product never
// moves at any other edge except under reset. A start seen at any edge,
// including during a running request, aborts that request, clears valid at
// that same edge, leaves product alone, and becomes the new E0. There is no
// back-pressure: the result is simply held in DONE until the next start.
// -----------------------------------------------------------------------------
module multiplier (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  quotientin,
    input  logic [6:0]  divisorin,
    input  logic [6:0]  remainderin,
    output logic [14:0] product,
    output logic        valid,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        PAD  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Last shift-add step: bit counter value 7 (E9).
    localparam logic [2:0] BIT_LAST = 3'd7;
    // PAD is entered at E9 with the counter at 0 and counts once per edge
    // E10..E16; at E17 the counter reads 7 and the result is published.
    localparam logic [4:0] PAD_LAST = 5'd7;

    state_t        state_q,   state_d;
    logic [14:0]   acc_q,     acc_d;
    logic [7:0]    quot_q,    quot_d;
    logic [6:0]    div_q,     div_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [4:0]    pad_cnt_q, pad_cnt_d;
    logic [14:0]   product_q, product_d;
    logic          valid_q,   valid_d;

    // divisor shifted to the weight of the quotient bit being processed.
    // 127 << 7 fits in 15 bits, and the accumulated total is bounded by
    // 255*127 + 127 = 32512, so no carry is ever lost.
    logic [14:0]   add_term;

    assign add_term = {8'd0, div_q} << bit_cnt_q;

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        quot_d    = quot_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        pad_cnt_d = pad_cnt_q;
        product_d = product_q;
        valid_d   = valid_q;

        if (start) begin
            // Start wins in every state: abandon whatever was running. The
            // partial accumulator is left alone; LOAD overwrites it.
            state_d = LOAD;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end

                LOAD: begin
                    quot_d    = quotientin;
                    div_d     = divisorin;
                    acc_d     = {8'd0, remainderin};
                    bit_cnt_d = 3'd0;
                    pad_cnt_d = 5'd0;
                    state_d   = MUL;
                end

                MUL: begin
                    if (quot_q[bit_cnt_q]) begin
                        acc_d = acc_q + add_term;
                    end
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) begin
                        pad_cnt_d = 5'd0;
                        state_d   = PAD;
                    end
                end

                PAD: begin
                    if (pad_cnt_q == PAD_LAST) begin
                        product_d = acc_q;
                        valid_d   = 1'b1;
                        pad_cnt_d = 5'd0;
                        state_d   = DONE;
                    end else begin
                        pad_cnt_d = pad_cnt_q + 5'd1;
                    end
                end

                DONE: begin
                    state_d = DONE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            acc_q     <= 15'd0;
            quot_q    <= 8'd0;
            div_q     <= 7'd0;
            bit_cnt_q <= 3'd0;
            pad_cnt_q <= 5'd0;
            product_q <= 15'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            quot_q    <= quot_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            pad_cnt_q <= pad_cnt_d;
            product_q <= product_d;
            valid_q   <= valid_d;
        end
    end

    assign product   = product_q;
    assign valid     = valid_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multiplier.sv
module tb_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  quotientin;
  logic [6:0]  divisorin;
  logic [6:0]  remainderin;
  logic [14:0] product;
  logic        valid;
  logic [2:0]  state_dbg;

  int n_vec;
  int n_err;
  logic [14:0] last_prod;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd4;

  multiplier dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .quotientin  (quotientin),
    .divisorin   (divisorin),
    .remainderin (remainderin),
    .product     (product),
    .valid       (valid),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one active edge, land 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive junk onto the operand inputs; they must be ignored
  task automatic junk();
    quotientin  = 8'($urandom_range(0, 255));
    divisorin   = 7'($urandom_range(0, 127));
    remainderin = 7'($urandom_range(0, 127));
  endtask

  // full request: start held for 'hold' edges, operands on the cycle after
  // the last start edge, result expected exactly at E17
  task automatic do_req(input string tag, input int hold, input int q, input int d,
                        input int r, input int exp);
    start = 1'b1;
    junk();
    repeat (hold) tick();
    // now just past E0
    chk({tag, "_valid_e0"}, int'(valid), 0);
    chk({tag, "_prod_e0"}, int'(product), int'(last_prod));
    start       = 1'b0;
    quotientin  = 8'(q);
    divisorin   = 7'(d);
    remainderin = 7'(r);
    tick();                       // E1: operand capture
    junk();
    repeat (15) tick();           // E2..E16
    chk({tag, "_valid_e16"}, int'(valid), 0);
    chk({tag, "_prod_e16"}, int'(product), int'(last_prod));
    tick();                       // E17
    chk({tag, "_prod_e17"}, int'(product), exp);
    chk({tag, "_valid_e17"}, int'(valid), 1);
    last_prod = 15'(exp);
    repeat (3) tick();            // DONE must hold
    chk({tag, "_hold_prod"}, int'(product), exp);
    chk({tag, "_hold_valid"}, int'(valid), 1);
  endtask

  initial begin
    int q, d, r;
    n_vec = 0;
    n_err = 0;
    last_prod = 15'd0;
    reset = 1'b0;
    start = 1'b0;
    quotientin  = 8'd0;
    divisorin   = 7'd0;
    remainderin = 7'd0;

    // reset state
    repeat (3) tick();
    chk("rst_prod", int'(product), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_state", int'(state_dbg), int'(ST_IDLE));

    // release reset with start already high: first edge must be honoured
    reset = 1'b1;
    do_req("basic", 1, 19, 13, 5, 252);
    chk("basic_state", int'(state_dbg), int'(ST_DONE));

    do_req("max", 1, 255, 127, 126, 32511);
    do_req("zero_q", 1, 0, 1, 0, 0);
    do_req("zero_d", 1, 200, 0, 77, 77);
    do_req("held_start", 3, 7, 9, 100, 163);

    // restart: first request aborted at E5, second must land 17 edges later
    start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    quotientin = 8'd10; divisorin = 7'd10; remainderin = 7'd0;
    tick();                       // E1
    junk();
    repeat (3) tick();            // E2..E4
    start = 1'b1;
    tick();                       // E5 = new E0
    chk("restart_valid_clr", int'(valid), 0);
    chk("restart_prod_hold", int'(product), int'(last_prod));
    start = 1'b0;
    quotientin = 8'd3; divisorin = 7'd4; remainderin = 7'd1;
    tick();                       // E1'
    junk();
    for (int i = 2; i <= 16; i++) begin
      tick();
      chk("restart_no_early", int'(product), int'(last_prod));
      chk("restart_valid_low", int'(valid), 0);
    end
    tick();                       // E17'
    chk("restart_prod", int'(product), 13);
    chk("restart_valid", int'(valid), 1);
    last_prod = 15'd13;

    // reset mid-operation, between E8 and E9
    start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    quotientin = 8'd50; divisorin = 7'd60; remainderin = 7'd70;
    tick();                       // E1
    junk();
    repeat (7) tick();            // E2..E8
    reset = 1'b0;
    #2;
    chk("midrst_prod", int'(product), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_state", int'(state_dbg), int'(ST_IDLE));
    #1;
    reset = 1'b1;
    last_prod = 15'd0;
    for (int i = 9; i <= 30; i++) begin
      tick();
      chk("midrst_no_valid", int'(valid), 0);
      chk("midrst_prod_zero", int'(product), 0);
    end
    do_req("after_rst", 1, 33, 3, 4, 103);

    // back-to-back random requests
    for (int i = 0; i < 50; i++) begin
      q = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 127));
      r = int'($urandom_range(0, 127));
      if (i % 4 == 0) begin
        d = int'($urandom_range(0, 20));
        r = int'($urandom_range(d, 127));
      end
      do_req("rand", 1, q, d, r, q * d + r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request pulse; operands are presented on the cycle after start.
REQ-006 quotientin  input  8  unsigned multiplicand.
REQ-007 divisorin  input  7  unsigned multiplier; 0 is legal.
REQ-008 remainderin  input  7  unsigned addend; not required to be less than divisorin.
REQ-009 product  output  15  quotientin*divisorin+remainderin, registered; maximum 32511 (0x7EFF), no overflow.
REQ-010 valid  output  1  high while product holds the result of the most recent completed request.

Function
REQ-011 Edge naming: E0 is the rising edge at which start is sampled high; En is the nth edge after E0.
REQ-012 Operand capture SHALL occur at E1 only; input values at every other edge are ignored.
REQ-013 States SHALL be IDLE, LOAD, MUL, PAD and DONE.
REQ-014 IDLE/DONE with start=1 at E0 -> LOAD; start=0 -> stay.
REQ-015 LOAD (E1) SHALL capture all three operands, set accumulator=remainderin (zero-extended) and set the bit counter to 0, then go to MUL.
REQ-016 MUL (E2..E9) SHALL perform one shift-add step per cycle, LSB first over the 8 quotient bits: if the current bit is 1, add divisorin<<k into the accumulator; after 8 steps go to PAD.
REQ-017 PAD (E10..E16) SHALL idle on a 5-bit cycle counter, so that total latency is exact.
REQ-018 At E17 the block SHALL load product from the accumulator, set valid=1 and enter DONE.
REQ-019 Latency is fixed: valid and the new product first appear after E17, and are visible at the falling edge following E17; one cycle early or late is a failure.
REQ-020 product SHALL change only at E17 or on reset; intermediate accumulator values never reach the output.
REQ-021 DONE SHALL hold product and valid=1 indefinitely until the next start or reset.
REQ-022 start=1 in any state (including LOAD, MUL or PAD) SHALL abort the current operation; that edge becomes a new E0, valid clears at that edge, product holds its old value, and the aborted result is never presented.
REQ-023 If start is held high for several cycles, each high edge restarts the sequence; latency is counted from the last high edge.
REQ-024 Accumulator SHALL be 15 bits; intermediate sums never exceed 15 bits, given the REQ-009 bound.
REQ-025 divisorin=0 or quotientin=0 SHALL yield product=remainderin.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, product=0, valid=0, accumulator=0 and all counters=0.
REQ-027 Reset asserted mid-operation SHALL discard the operation; no valid pulse follows release.
REQ-028 After reset deasserts, the block SHALL idle until start is sampled high; start sampled at the first edge after release SHALL be honoured.

Verification
REQ-029 Basic: start at E0; at E1 apply quotientin=19, divisorin=13, remainderin=5 -> at E17 product=252 and valid=1; at E16 valid=0 and product is unchanged.
REQ-030 Maximum: apply 255, 127, 126 -> product=32511 at E17; no wrap.
REQ-031 Zero: apply 0, 1, 0 -> product=0 and valid=1; separately apply 200, 0, 77 -> product=77.
REQ-032 Restart: start at E0 with 10, 10, 0, then start again at E5 with 3, 4, 1 -> valid clears at E5; product=13 exactly 17 edges after E5; product 100 never appears.
REQ-033 Reset mid-op: pulse reset low between E8 and E9 -> product=0 and valid=0 immediately, with no valid through E30; a following normal request completes in 17 cycles.
REQ-034 Back-to-back: 50 random requests with the same start timing as REQ-029, including remainderin >= divisorin -> every product equals quotientin*divisorin+remainderin at E17.
